// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan display: hex glyph table,
// blank segment pattern and the all-anodes-off value.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low g..a glyphs; the leftmost entry is index 15 (F), the rightmost is index 0.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH_TAB[nibble];

endmodule

// File: rtl/seg_scan_history.sv
// Four-deep pop history shown on a multiplexed 4-digit seven-segment display.
// Optional macro SEG_BLANK_INVALID_EN blanks digits whose history slot is not yet valid.
module seg_scan_history
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pop_strobe,
  input  logic       empty,
  input  logic [3:0] data_in,
  output logic [6:0] Sout,
  output logic [3:0] An,
  output logic [3:0] pop_cnt
);

  localparam int CNT_W = 16;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit_idx;
  logic [3:0][3:0]  hist;
  logic [3:0]       slot_vld;
  logic [3:0]       pop_cnt_q;
  logic             pop_ok;
  logic             scan_wrap;

  logic [6:0]       glyph_p0;
  logic [6:0]       disp_seg_p0;
  logic [6:0]       sout_p1;
  logic [3:0]       an_p1;

  assign pop_ok    = pop_strobe & ~empty;
  assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));

  // Stage p0: select the slot for the current digit and decode it
  hex_seg_decode u_hex_seg_decode (
    .nibble (hist[digit_idx]),
    .seg    (glyph_p0)
  );

`ifdef SEG_BLANK_INVALID_EN
  always_comb begin
    disp_seg_p0 = glyph_p0;
    if (!slot_vld[digit_idx]) disp_seg_p0 = SEG_BLANK;
  end
`else
  logic vld_unused;
  assign vld_unused  = ^slot_vld;
  assign disp_seg_p0 = glyph_p0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      hist      <= '0;
      slot_vld  <= '0;
      pop_cnt_q <= '0;
      sout_p1   <= SEG_BLANK;
      an_p1     <= AN_OFF;
    end else begin
      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt  <= scan_cnt + 1'b1;
      end

      if (pop_ok) begin
        hist     <= {hist[2:0], data_in};
        slot_vld <= {slot_vld[2:0], 1'b1};
        if (pop_cnt_q != 4'hF) pop_cnt_q <= pop_cnt_q + 4'd1;
      end

      // Stage p1: registered display outputs, one cycle behind index/history
      sout_p1 <= disp_seg_p0;
      an_p1   <= ~(4'b0001 << digit_idx);
    end
  end

  assign Sout    = sout_p1;
  assign An      = an_p1;
  assign pop_cnt = pop_cnt_q;

endmodule

// File: tb/tb_seg_scan_history.sv
// Directed bench for seg_scan_history with SCAN_DIV=4 (honours SEG_BLANK_INVALID_EN).
module tb_seg_scan_history;

  logic       clk = 1'b0;
  logic       reset;
  logic       pop_strobe;
  logic       empty;
  logic [3:0] data_in;
  logic [6:0] Sout;
  logic [3:0] An;
  logic [3:0] pop_cnt;

  int tests  = 0;
  int failed = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BLANK = 7'b1111111;

`ifdef SEG_BLANK_INVALID_EN
  localparam logic [6:0] IDLE_SEG = BLANK;
`else
  localparam logic [6:0] IDLE_SEG = G0;
`endif

  typedef struct {
    logic       pop;
    logic       emp;
    logic [3:0] data;
    logic [3:0] exp_cnt;
  } pop_vec_t;

  typedef struct {
    logic [3:0] exp_an;
    logic [6:0] exp_sout;
  } idle_vec_t;

  seg_scan_history #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pop_strobe (pop_strobe),
    .empty      (empty),
    .data_in    (data_in),
    .Sout       (Sout),
    .An         (An),
    .pop_cnt    (pop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pop_strobe = 1'b0; empty = 1'b0; data_in = 4'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) until the given anode is active, then check the glyph on it.
  task automatic check_digit(input string name, input logic [3:0] an_want, input logic [6:0] seg_want);
    bit seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (An == an_want) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      failed++;
      $display("FAIL %s: anode %0h never seen, last %0h", name, an_want, An);
    end else begin
      check(name, {25'd0, Sout}, {25'd0, seg_want});
    end
  endtask

  pop_vec_t  pops[6];
  idle_vec_t idle[20];
  pop_vec_t  sat[18];

  initial begin
    pops[0] = '{1'b1, 1'b0, 4'h1, 4'd1};
    pops[1] = '{1'b1, 1'b0, 4'h2, 4'd2};
    pops[2] = '{1'b1, 1'b0, 4'h3, 4'd3};
    pops[3] = '{1'b1, 1'b0, 4'h4, 4'd4};
    pops[4] = '{1'b1, 1'b1, 4'hF, 4'd4};
    pops[5] = '{1'b0, 1'b0, 4'h9, 4'd4};
    for (int k = 0; k < 20; k++) begin
      case ((k / 4) % 4)
        0:       idle[k] = '{4'b1110, IDLE_SEG};
        1:       idle[k] = '{4'b1101, IDLE_SEG};
        2:       idle[k] = '{4'b1011, IDLE_SEG};
        default: idle[k] = '{4'b0111, IDLE_SEG};
      endcase
    end
    for (int k = 0; k < 18; k++)
      sat[k] = '{1'b1, 1'b0, 4'(k), (k < 15) ? 4'(k + 1) : 4'd15};

    // Reset state, then free-running scan with empty history
    do_reset();
    reset = 1'b1;
    tick();
    check("rst_sout", {25'd0, Sout}, {25'd0, BLANK});
    check("rst_an", {28'd0, An}, {28'd0, 4'b1111});
    check("rst_cnt", {28'd0, pop_cnt}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("idle_an[%0d]", k), {28'd0, An}, {28'd0, idle[k].exp_an});
      check($sformatf("idle_sout[%0d]", k), {25'd0, Sout}, {25'd0, idle[k].exp_sout});
    end

    // Pops 1..4, an ignored pop while empty, then an idle cycle
    for (int k = 0; k < 6; k++) begin
      pop_strobe = pops[k].pop; empty = pops[k].emp; data_in = pops[k].data;
      tick();
      check($sformatf("pop_cnt[%0d]", k), {28'd0, pop_cnt}, {28'd0, pops[k].exp_cnt});
    end
    pop_strobe = 1'b0; empty = 1'b0;
    check_digit("hist_d0", 4'b1110, G4);
    check_digit("hist_d1", 4'b1101, G3);
    check_digit("hist_d2", 4'b1011, G2);
    check_digit("hist_d3", 4'b0111, G1);

    // Saturation: 18 back-to-back pops of 0..17 (mod 16)
    do_reset();
    for (int k = 0; k < 18; k++) begin
      pop_strobe = sat[k].pop; empty = sat[k].emp; data_in = sat[k].data;
      tick();
      check($sformatf("sat_cnt[%0d]", k), {28'd0, pop_cnt}, {28'd0, sat[k].exp_cnt});
    end
    pop_strobe = 1'b0;
    check_digit("sat_d0", 4'b1110, G1);
    check_digit("sat_d1", 4'b1101, G0);
    check_digit("sat_d2", 4'b1011, GF);
    check_digit("sat_d3", 4'b0111, GE);
    check("sat_hold", {28'd0, pop_cnt}, 32'd15);

    // Reset during digit 2 with a coincident pop: pop must be discarded
    check_digit("pre_rst_d2", 4'b1011, GF);
    reset = 1'b1; pop_strobe = 1'b1; empty = 1'b0; data_in = 4'h7;
    tick();
    reset = 1'b0; pop_strobe = 1'b0;
    check("mid_rst_sout", {25'd0, Sout}, {25'd0, BLANK});
    check("mid_rst_an", {28'd0, An}, {28'd0, 4'b1111});
    check("mid_rst_cnt", {28'd0, pop_cnt}, 32'd0);
    tick();
    check("rel_an", {28'd0, An}, {28'd0, 4'b1110});
    check("rel_sout", {25'd0, Sout}, {25'd0, IDLE_SEG});
    check("rel_cnt", {28'd0, pop_cnt}, 32'd0);

    // Pop landing on the 3->0 digit wrap (edge 16 after release)
    do_reset();
    for (int k = 0; k < 15; k++) tick();
    pop_strobe = 1'b1; data_in = 4'hA;
    tick();
    pop_strobe = 1'b0;
    check("wrap_an_d3", {28'd0, An}, {28'd0, 4'b0111});
    check("wrap_sout_d3", {25'd0, Sout}, {25'd0, IDLE_SEG});
    tick();
    check("wrap_an_d0", {28'd0, An}, {28'd0, 4'b1110});
    check("wrap_sout_d0", {25'd0, Sout}, {25'd0, GA});
    check("wrap_cnt", {28'd0, pop_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg_scan_history.md
SEG_SCAN_HISTORY -- requirements
Module: seg_scan_history

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clk cycles each digit is held active (legal range 2..65535).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: pop_strobe  input  1  one-cycle pulse marking that a queue entry was popped and data_in is valid.
REQ-005 Port: empty  input  1  upstream queue empty flag, sampled together with pop_strobe.
REQ-006 Port: data_in  input  4  popped queue data (hex nibble).
REQ-007 Port: Sout  output  7  segment drive, bit 6..0 = g..a, active-low, registered.
REQ-008 Port: An  output  4  digit anode select, one-hot active-low, registered.
REQ-009 Port: pop_cnt  output  4  number of accepted pops, saturating at 15.

Function
REQ-010 The block SHALL hold a 4-slot history H0..H3 of 4-bit values with a valid bit per slot; H0 is newest.
REQ-011 An accepted pop (pop_strobe=1 and empty=0) SHALL shift Hk<=Hk-1 for k=3..1, H0<=data_in, V0<=1, Vk<=Vk-1, on the same rising edge.
REQ-012 pop_strobe with empty=1 SHALL be ignored: no shift, pop_cnt unchanged.
REQ-013 pop_strobe held high N consecutive cycles with empty=0 SHALL produce N shifts.
REQ-014 pop_cnt SHALL increment by 1 per accepted pop and hold at 15.
REQ-015 A scan counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index SHALL advance 0->1->2->3->0.
REQ-016 Digit index d SHALL display slot Hd; An bit d low, other bits high.
REQ-017 Sout and An SHALL be registered from the current digit index and slot contents, latency exactly 1 cycle after index change or history shift.
REQ-018 Sout SHALL encode hex 0-F with the standard 0-9, A, b, C, d, E, F glyphs.
REQ-019 A shift occurring in the same cycle as a digit advance SHALL be fully applied; the next registered Sout reflects the shifted history for the new digit.

Reset
REQ-020 While reset=1 at a clock edge: H0..H3=0, V0..V3=0, pop_cnt=0, scan counter=0, digit index=0, Sout=7'b1111111, An=4'b1111.
REQ-021 First cycle after reset release SHALL drive An=4'b1110 with digit 0 content.
REQ-022 reset SHALL take priority over a coincident pop_strobe; the pop is discarded.

Configuration
REQ-023 Macro SEG_BLANK_INVALID_EN: when defined, a digit whose valid bit is 0 SHALL drive Sout=7'b1111111 (blank).
REQ-024 Without SEG_BLANK_INVALID_EN, invalid slots SHALL display their stored value (0 after reset).

Structure
REQ-025 Shared package seg_pkg SHALL hold the 16-entry glyph table constants, the blank pattern 7'b1111111 and the anode-off value 4'b1111.
REQ-026 Glyph decode SHALL be a sub-module hex_seg_decode (4-bit in, 7-bit active-low out, purely combinational); history, counter and output registers stay in seg_scan_history.

Verification (SCAN_DIV=4 on bench)
REQ-027 Reset then 20 idle cycles -> An cycles 1110,1101,1011,0111 every 4 cycles; with macro Sout=1111111 throughout, without macro Sout=1000000 ("0").
REQ-028 Pops of 1,2,3,4 (empty=0) -> digit0 shows 4 (0011001), digit3 shows 1 (1111001), pop_cnt=4.
REQ-029 pop_strobe=1 with empty=1, data_in=F -> history and pop_cnt unchanged.
REQ-030 18 accepted pops -> pop_cnt holds 15; H0..H3 hold the last four values.
REQ-031 Assert reset mid-scan (digit 2) with pop_strobe=1 -> next cycle all REQ-020 values, pop discarded; digit 0 resumes on release.
REQ-032 Pop coincident with digit wrap 3->0 -> Sout one cycle later shows new data_in on digit 0.
